// File: rtl/cpu_run_ctrl.sv
// CPU run controller: debounced step/run keys, reset hold, single-step,
// free-run with one hardware breakpoint, and a saturating retire counter.
module cpu_run_ctrl #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_step_n,
    input  logic        key_run_n,
    input  logic [15:0] pc,
    input  logic [15:0] bp_addr,
    input  logic        bp_en,
    output logic        cpu_rst,
    output logic        cpu_en,
    output logic [2:0]  state_o,
    output logic [15:0] instr_count
);

    localparam int unsigned DEB_W  = 20;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        HALTED   = 3'd1,
        STEP     = 3'd2,
        RUN      = 3'd3,
        BREAK    = 3'd4,
        RESUME   = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              step_sync1;
    logic              step_sync2;
    logic              step_level;
    logic [DEB_W-1:0]  step_cnt;
    logic              step_press;

    logic              run_sync1;
    logic              run_sync2;
    logic              run_level;
    logic [DEB_W-1:0]  run_cnt;
    logic              run_press;

    logic [HOLD_W-1:0] hold_cnt;
    logic              bp_hit;

    // Step key: synchronize, debounce, pulse on accepted press (high-to-low)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_sync1 <= 1'b1;
            step_sync2 <= 1'b1;
            step_level <= 1'b1;
            step_cnt   <= '0;
            step_press <= 1'b0;
        end else begin
            step_sync1 <= key_step_n;
            step_sync2 <= step_sync1;
            step_press <= 1'b0;
            if (step_sync2 != step_level) begin
                if (step_cnt == DEB_LAST) begin
                    step_level <= step_sync2;
                    step_cnt   <= '0;
                    step_press <= ~step_sync2;
                end else begin
                    step_cnt <= step_cnt + DEB_W'(1);
                end
            end else begin
                step_cnt <= '0;
            end
        end
    end

    // Run key: synchronize, debounce, pulse on accepted press (high-to-low)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_sync1 <= 1'b1;
            run_sync2 <= 1'b1;
            run_level <= 1'b1;
            run_cnt   <= '0;
            run_press <= 1'b0;
        end else begin
            run_sync1 <= key_run_n;
            run_sync2 <= run_sync1;
            run_press <= 1'b0;
            if (run_sync2 != run_level) begin
                if (run_cnt == DEB_LAST) begin
                    run_level <= run_sync2;
                    run_cnt   <= '0;
                    run_press <= ~run_sync2;
                end else begin
                    run_cnt <= run_cnt + DEB_W'(1);
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset-hold timer, only advances while holding the core in reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state_q == RST_HOLD) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // Next state and clock enable; run press wins over a simultaneous step press
    always_comb begin
        state_d = state_q;
        cpu_en  = 1'b0;
        bp_hit  = bp_en && (pc == bp_addr);
        case (state_q)
            RST_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_d = HALTED;
            end
            HALTED: begin
                if (run_press)       state_d = RUN;
                else if (step_press) state_d = STEP;
            end
            STEP: begin
                cpu_en  = 1'b1;
                state_d = HALTED;
            end
            RUN: begin
                cpu_en = ~bp_hit;
                if (bp_hit)         state_d = BREAK;
                else if (run_press) state_d = HALTED;
            end
            BREAK: begin
                if (run_press)       state_d = RESUME;
                else if (step_press) state_d = STEP;
            end
            RESUME: begin
                cpu_en  = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RST_HOLD;
            end
        endcase
    end

    // Retired-instruction counter, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (cpu_en && (instr_count != CNT_MAX)) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign cpu_rst = (state_q == RST_HOLD);
    assign state_o = state_q;

endmodule
